qspi_xfer_arbiter: RTL and testbench

QSPI_XFER_ARBITER -- requirements
Module: qspi_xfer_arbiter

---
 rtl/qspi_xfer_arbiter.sv | 164 ++++++++++++++++
 tb/tb_qspi_xfer_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_xfer_arbiter.sv
// Round-robin arbiter feeding one QSPI flash FSM from two descriptor sources; accept->start is 1 cycle.
// Define QSPI_ARB_TIMEOUT_EN to bound the BUSY wait by TIMEOUT_CYCLES (forced completion with err).
module qspi_xfer_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_opcode,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_len,
  input  logic        req0_dir,
  input  logic [15:0] req0_cfg,
  output logic        req0_done,
  output logic        req0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_opcode,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_len,
  input  logic        req1_dir,
  input  logic [15:0] req1_cfg,
  output logic        req1_done,
  output logic        req1_err,
  output logic        start,
  input  logic        fsm_done,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] addr,
  output logic [31:0] len_bytes,
  output logic        dir,
  output logic [1:0]  cmd_lanes_sel,
  output logic [1:0]  addr_lanes_sel,
  output logic [1:0]  data_lanes_sel,
  output logic [1:0]  addr_bytes_sel,
  output logic        mode_en,
  output logic [3:0]  dummy_cycles,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, COMPLETE} state_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] addr;
    logic [31:0] len;
    logic        dir;
    logic [1:0]  cmd_lanes;
    logic [1:0]  addr_lanes;
    logic [1:0]  data_lanes;
    logic [1:0]  addr_bytes;
    logic        mode_en;
    logic [3:0]  dummy;
  } desc_t;

  localparam logic [31:0] TIMEOUT_LIM = TIMEOUT_CYCLES - 1;

  function automatic desc_t to_desc(input logic [7:0] op, input logic [31:0] a,
                                    input logic [31:0] len, input logic d,
                                    input logic [12:0] cfg);
    desc_t r;
    r.opcode     = op;
    r.addr       = a;
    r.len        = len;
    r.dir        = d;
    r.cmd_lanes  = cfg[1:0];
    r.addr_lanes = cfg[3:2];
    r.data_lanes = cfg[5:4];
    r.addr_bytes = cfg[7:6];
    r.mode_en    = cfg[8];
    r.dummy      = cfg[12:9];
    return r;
  endfunction

  state_t state, state_nxt;
  desc_t  desc_q;
  logic   idx_q;
  logic   last_idx;
  logic   grant_idx;
  logic   accept;
  logic   timeout_hit;
  logic   xfer_err;

  // last_idx holds the most recently served requester; reset value 1 favours requester 0
  assign grant_idx = (req0_valid && req1_valid) ? ~last_idx : req1_valid;
  assign accept    = ~reset && (state == IDLE) && (req0_valid || req1_valid);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req0_valid || req1_valid) state_nxt = LAUNCH;
      LAUNCH:   state_nxt = BUSY;
      BUSY:     if (fsm_done || timeout_hit) state_nxt = COMPLETE;
      COMPLETE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      desc_q   <= '0;
      idx_q    <= 1'b0;
      last_idx <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx_q  <= grant_idx;
        desc_q <= grant_idx ? to_desc(req1_opcode, req1_addr, req1_len, req1_dir, req1_cfg[12:0])
                            : to_desc(req0_opcode, req0_addr, req0_len, req0_dir, req0_cfg[12:0]);
      end
      if (state == COMPLETE) last_idx <= idx_q;
    end
  end

`ifdef QSPI_ARB_TIMEOUT_EN
  logic [31:0] busy_cnt;
  logic        err_q;

  assign timeout_hit = (state == BUSY) && (busy_cnt == TIMEOUT_LIM);
  assign xfer_err    = err_q;

  // err_q is re-evaluated every BUSY cycle; fsm_done on the limit cycle wins
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == LAUNCH)    busy_cnt <= '0;
      else if (state == BUSY) busy_cnt <= busy_cnt + 32'd1;
      if (state == BUSY)      err_q <= timeout_hit & ~fsm_done;
    end
  end
`else
  logic unused_lim;
  assign unused_lim  = ^TIMEOUT_LIM;
  assign timeout_hit = 1'b0;
  assign xfer_err    = 1'b0;
`endif

  logic unused_cfg;
  assign unused_cfg = ^{req0_cfg[15:13], req1_cfg[15:13]};

  assign req0_ready = accept & ~grant_idx;
  assign req1_ready = accept & grant_idx;
  assign start      = (state == LAUNCH);
  assign busy       = (state != IDLE);
  assign req0_done  = (state == COMPLETE) && !idx_q;
  assign req1_done  = (state == COMPLETE) && idx_q;
  assign req0_err   = req0_done & xfer_err;
  assign req1_err   = req1_done & xfer_err;

  assign cmd_opcode     = desc_q.opcode;
  assign addr           = desc_q.addr;
  assign len_bytes      = desc_q.len;
  assign dir            = desc_q.dir;
  assign cmd_lanes_sel  = desc_q.cmd_lanes;
  assign addr_lanes_sel = desc_q.addr_lanes;
  assign data_lanes_sel = desc_q.data_lanes;
  assign addr_bytes_sel = desc_q.addr_bytes;
  assign mode_en        = desc_q.mode_en;
  assign dummy_cycles   = desc_q.dummy;

endmodule

// File: tb/tb_qspi_xfer_arbiter.sv
// Bench for qspi_xfer_arbiter: vector table plus hand sequences, descriptor/done scoreboard.
module tb_qspi_xfer_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_dir, req0_done, req0_err;
  logic [7:0]  req0_opcode;
  logic [31:0] req0_addr, req0_len;
  logic [15:0] req0_cfg;
  logic        req1_valid, req1_ready, req1_dir, req1_done, req1_err;
  logic [7:0]  req1_opcode;
  logic [31:0] req1_addr, req1_len;
  logic [15:0] req1_cfg;
  logic        start, fsm_done, dir, mode_en, busy;
  logic [7:0]  cmd_opcode;
  logic [31:0] addr, len_bytes;
  logic [1:0]  cmd_lanes_sel, addr_lanes_sel, data_lanes_sel, addr_bytes_sel;
  logic [3:0]  dummy_cycles;

  qspi_xfer_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_addr(req0_addr), .req0_len(req0_len), .req0_dir(req0_dir), .req0_cfg(req0_cfg),
    .req0_done(req0_done), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_addr(req1_addr), .req1_len(req1_len), .req1_dir(req1_dir), .req1_cfg(req1_cfg),
    .req1_done(req1_done), .req1_err(req1_err),
    .start(start), .fsm_done(fsm_done), .cmd_opcode(cmd_opcode), .addr(addr),
    .len_bytes(len_bytes), .dir(dir), .cmd_lanes_sel(cmd_lanes_sel),
    .addr_lanes_sel(addr_lanes_sel), .data_lanes_sel(data_lanes_sel),
    .addr_bytes_sel(addr_bytes_sel), .mode_en(mode_en), .dummy_cycles(dummy_cycles),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        idx;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] l;
    logic        d;
    logic [15:0] cfg;
    logic        err;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        v0, v1;
    logic [7:0]  op0, op1;
    logic [31:0] a0, a1, l0, l1;
    logic        d0, d1;
    logic [15:0] c0, c1;
    int          lat;
    logic        stray;
    logic        win;
  } vec_t;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk_exp(input logic idx, input logic err);
    exp_t e;
    e.idx = idx;
    e.err = err;
    e.op  = idx ? req1_opcode : req0_opcode;
    e.a   = idx ? req1_addr   : req0_addr;
    e.l   = idx ? req1_len    : req0_len;
    e.d   = idx ? req1_dir    : req0_dir;
    e.cfg = idx ? req1_cfg    : req0_cfg;
    return e;
  endfunction

  function automatic vec_t mkv(input logic rst, input logic v0, input logic v1,
                               input logic [7:0] op0, input logic [31:0] a0, input logic [31:0] l0,
                               input logic d0, input logic [15:0] c0,
                               input logic [7:0] op1, input logic [31:0] a1, input logic [31:0] l1,
                               input logic d1, input logic [15:0] c1,
                               input int lat, input logic stray, input logic win);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.v1 = v1;
    v.op0 = op0; v.a0 = a0; v.l0 = l0; v.d0 = d0; v.c0 = c0;
    v.op1 = op1; v.a1 = a1; v.l1 = l1; v.d1 = d1; v.c1 = c1;
    v.lat = lat; v.stray = stray; v.win = win;
    return v;
  endfunction

  // Descriptor outputs are compared while start is high; done/err pops the scoreboard
  always @(negedge clk) begin
    if (start) begin
      if (exp_q.size() == 0) chk("start_unexpected", 1, 0);
      else begin
        mon_e = exp_q[0];
        chk("cmd_opcode", cmd_opcode, mon_e.op);
        chk("addr", addr, mon_e.a);
        chk("len_bytes", len_bytes, mon_e.l);
        chk("dir", dir, mon_e.d);
        chk("cmd_lanes", cmd_lanes_sel, mon_e.cfg[1:0]);
        chk("addr_lanes", addr_lanes_sel, mon_e.cfg[3:2]);
        chk("data_lanes", data_lanes_sel, mon_e.cfg[5:4]);
        chk("addr_bytes", addr_bytes_sel, mon_e.cfg[7:6]);
        chk("mode_en", mode_en, mon_e.cfg[8]);
        chk("dummy", dummy_cycles, mon_e.cfg[12:9]);
      end
    end
    if (req0_done || req1_done) begin
      if (exp_q.size() == 0) chk("done_unexpected", {req1_done, req0_done}, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("done_pair", {req1_done, req0_done}, mon_e.idx ? 2'b10 : 2'b01);
        chk("err", mon_e.idx ? req1_err : req0_err, mon_e.err);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    fsm_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Call with valids driven in IDLE; returns in the LAUNCH cycle with the winner's valid dropped
  task automatic accept(input logic win, input logic err);
    int n = 0;
    #1;
    while (!(req0_ready || req1_ready) && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk("accept_wait", req0_ready | req1_ready, 1);
    chk("ready_pair", {req1_ready, req0_ready}, win ? 2'b10 : 2'b01);
    exp_q.push_back(mk_exp(win, err));
    tick();
    if (win) req1_valid = 1'b0;
    else     req0_valid = 1'b0;
    #1;
    chk("start_latency", start, 1);
    chk("ready_in_launch", {req1_ready, req0_ready}, 2'b00);
  endtask

  // From LAUNCH: fsm_done goes high lat cycles after start, done expected one cycle later
  task automatic finish_xfer(input logic win, input int lat);
    for (int k = 1; k < lat; k++) begin
      tick();
      fsm_done = 1'b0;
      chk("start_once", start, 0);
      chk("no_early_done", {req1_done, req0_done}, 2'b00);
    end
    tick();
    fsm_done = 1'b1;
    chk("busy_in_xfer", busy, 1);
    tick();
    fsm_done = 1'b0;
    chk("done_after_fsm", {req1_done, req0_done}, win ? 2'b10 : 2'b01);
    tick();
    chk("done_one_cycle", {req1_done, req0_done}, 2'b00);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    vecs[0] = mkv(1, 1, 0, 8'h06, 32'h0, 32'h0, 0, 16'h0000,
                  8'h00, 32'h0, 32'h0, 0, 16'h0000, 5, 0, 0);
    vecs[1] = mkv(1, 1, 1, 8'h6B, 32'h0000_1000, 32'd256, 1, 16'h1155,
                  8'hEB, 32'h0020_0000, 32'd64, 1, 16'h0AEE, 3, 0, 0);
    vecs[2] = mkv(0, 1, 1, 8'h02, 32'h0000_2000, 32'd16, 0, 16'h0040,
                  8'hEB, 32'h0020_0000, 32'd64, 1, 16'h0AEE, 2, 0, 1);
    vecs[3] = mkv(0, 1, 1, 8'h32, 32'h0000_3000, 32'd1, 0, 16'h0024,
                  8'hEB, 32'h0020_0000, 32'd64, 1, 16'h0AEE, 1, 0, 0);
    vecs[4] = mkv(0, 0, 1, 8'h00, 32'h0, 32'h0, 0, 16'h0000,
                  8'h0B, 32'h00F0_0F00, 32'd7, 1, 16'h1E9B, 4, 1, 1);
    vecs[5] = mkv(0, 0, 1, 8'h00, 32'h0, 32'h0, 0, 16'h0000,
                  8'h9F, 32'h0000_0003, 32'd3, 1, 16'h6011, 2, 0, 1);
    vecs[6] = mkv(0, 1, 0, 8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 16'hFFFF,
                  8'h00, 32'h0, 32'h0, 0, 16'h0000, 2, 1, 0);

    // Reset with both requesters valid and non-zero descriptors driven
    reset = 1'b1;
    fsm_done = 1'b0;
    req0_valid = 1'b1; req0_opcode = 8'hA5; req0_addr = 32'hDEAD_BEEF;
    req0_len = 32'h55; req0_dir = 1'b1; req0_cfg = 16'h1FFF;
    req1_valid = 1'b1; req1_opcode = 8'h5A; req1_addr = 32'h1234_5678;
    req1_len = 32'hAA; req1_dir = 1'b1; req1_cfg = 16'h1FFF;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_done_err", {req1_done, req0_done, req1_err, req0_err}, 4'h0);
    chk("rst_desc", {cmd_opcode, addr, len_bytes, dir}, 73'h0);
    chk("rst_sel", {cmd_lanes_sel, addr_lanes_sel, data_lanes_sel, addr_bytes_sel,
                    mode_en, dummy_cycles}, 13'h0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst) do_reset();
      req0_valid = vecs[i].v0; req0_opcode = vecs[i].op0; req0_addr = vecs[i].a0;
      req0_len = vecs[i].l0; req0_dir = vecs[i].d0; req0_cfg = vecs[i].c0;
      req1_valid = vecs[i].v1; req1_opcode = vecs[i].op1; req1_addr = vecs[i].a1;
      req1_len = vecs[i].l1; req1_dir = vecs[i].d1; req1_cfg = vecs[i].c1;
      fsm_done = vecs[i].stray;
      accept(vecs[i].win, 1'b0);
      finish_xfer(vecs[i].win, vecs[i].lat);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // req1 arrives while req0 is in flight: it waits and req0's address stays on the bus
    do_reset();
    req0_valid = 1'b1; req0_opcode = 8'h03; req0_addr = 32'h1122_3344;
    req0_len = 32'd4; req0_dir = 1'b1; req0_cfg = 16'h0000;
    accept(1'b0, 1'b0);
    req1_valid = 1'b1; req1_opcode = 8'h0B; req1_addr = 32'h00AB_CDEF;
    req1_len = 32'd8; req1_dir = 1'b1; req1_cfg = 16'h02A5;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("held_ready1", req1_ready, 0);
      chk("held_addr", addr, 32'h1122_3344);
      tick();
    end
    fsm_done = 1'b1;
    tick();
    fsm_done = 1'b0;
    #1;
    chk("held_done0", req0_done, 1);
    chk("held_ready1_complete", req1_ready, 0);
    chk("held_addr_complete", addr, 32'h1122_3344);
    tick();
    accept(1'b1, 1'b0);
    finish_xfer(1'b1, 2);

    // Reset two cycles into BUSY abandons the transfer silently
    do_reset();
    req0_valid = 1'b1; req0_opcode = 8'h38; req0_addr = 32'h0000_ABCD;
    req0_len = 32'd32; req0_dir = 1'b0; req0_cfg = 16'h0155;
    accept(1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("abort_busy", busy, 0);
    chk("abort_start_done", {start, req1_done, req0_done}, 3'b000);
    chk("abort_desc", {cmd_opcode, addr, len_bytes, dir}, 73'h0);
    chk("abort_sel", {cmd_lanes_sel, addr_lanes_sel, data_lanes_sel, addr_bytes_sel,
                      mode_en, dummy_cycles}, 13'h0);
    for (int k = 0; k < 5; k++) tick();
    chk("abort_quiet", {busy, req1_done, req0_done}, 3'b000);
    req1_valid = 1'b1; req1_opcode = 8'h05; req1_addr = 32'h0000_0040;
    req1_len = 32'd1; req1_dir = 1'b1; req1_cfg = 16'h0000;
    accept(1'b1, 1'b0);
    finish_xfer(1'b1, 3);

    // fsm_done on the 16th BUSY cycle completes cleanly in either build
    req0_valid = 1'b1; req0_opcode = 8'h20; req0_addr = 32'h0001_0000;
    req0_len = 32'd0; req0_dir = 1'b0; req0_cfg = 16'h0000;
    accept(1'b0, 1'b0);
    finish_xfer(1'b0, 16);

    // fsm_done never arrives
    do_reset();
    req0_valid = 1'b1; req0_opcode = 8'h9F; req0_addr = 32'h0000_0100;
    req0_len = 32'd3; req0_dir = 1'b1; req0_cfg = 16'h0000;
`ifdef QSPI_ARB_TIMEOUT_EN
    accept(1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("to_wait_done", {req1_done, req0_done}, 2'b00);
      chk("to_wait_busy", busy, 1);
    end
    tick();
    chk("to_done0", req0_done, 1);
    chk("to_err0", req0_err, 1);
    tick();
    chk("to_idle", busy, 0);
`else
    accept(1'b0, 1'b0);
    for (int k = 0; k < 40; k++) tick();
    chk("no_to_busy", busy, 1);
    chk("no_to_done", {req1_done, req0_done}, 2'b00);
    do_reset();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
